lcd_char_driver: RTL and testbench

Character-LCD responder for the front-panel UI: holds a 2×16 character frame buffer written through a byte/address/write-enable port and, on a repaint request, streams the whole frame to an HD44780-compatible display over its 4-bit bus (RW tied low). It runs the display power-on initialisation autonomously after reset. Its upstream is the UI menu/readout logic, which writes characters and pulses repaint; its downstream is the LCD pins.

---
 rtl/lcd_pkg.sv | 71 +++++++
 rtl/lcd_nibble_tx.sv | 131 +++++++++++++
 rtl/lcd_char_driver.sv | 168 ++++++++++++++++
 tb/tb_lcd_char_driver.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg -- shared definitions for the character-LCD driver.
//   * HD44780 command bytes used by the init and paint sequences
//   * sequencer and nibble-transmitter state encodings
//   * default timing values (clk cycles at 50 MHz)
//   * transfer request struct and small decode helpers
// ---------------------------------------------------------------------------
package lcd_pkg;

   // HD44780 command bytes
   localparam logic [7:0] FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] ENTRY    = 8'h06;  // increment, no shift
   localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] LINE1    = 8'h80;  // DDRAM address 0x00
   localparam logic [7:0] LINE2    = 8'hC0;  // DDRAM address 0x40

   // One paint = line-1 address, 16 chars, line-2 address, 16 chars
   localparam int unsigned PAINT_LEN  = 34;
   localparam logic [5:0]  PAINT_LAST = 6'd33;
   localparam logic [5:0]  LINE2_IDX  = 6'd17;

   // Default timing, clk cycles at 50 MHz
   localparam int unsigned DEF_T_PWRUP = 750000;
   localparam int unsigned DEF_T_INIT1 = 205000;
   localparam int unsigned DEF_T_INIT2 = 5000;
   localparam int unsigned DEF_T_SETUP = 2;
   localparam int unsigned DEF_T_EHIGH = 12;
   localparam int unsigned DEF_T_NIB   = 50;
   localparam int unsigned DEF_T_CMD   = 2000;
   localparam int unsigned DEF_T_CLR   = 82000;

   typedef enum logic [2:0] {
      S_PWR_WAIT,
      S_INIT,
      S_CFG,
      S_IDLE,
      S_PAINT
   } lcd_state_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_SETUP,
      TX_EHI,
      TX_GAP,
      TX_WAIT
   } tx_phase_e;

   // One transfer handed to the nibble transmitter
   typedef struct packed {
      logic [7:0]  data;
      logic        rs;
      logic        nib_only;   // send data[7:4] only
      logic [31:0] wait_cyc;   // idle time after the last E fall
   } lcd_req_t;

   function automatic logic [7:0] cfg_byte(input logic [1:0] i);
      case (i)
         2'd0:    return FUNC_SET;
         2'd1:    return ENTRY;
         2'd2:    return DISP_ON;
         default: return CLEAR;
      endcase
   endfunction

   // Paint step -> buffer position (steps 0 and 17 are address commands)
   function automatic logic [4:0] paint_pos(input logic [5:0] idx);
      return 5'(idx - ((idx <= 6'd16) ? 6'd1 : 6'd2));
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// ---------------------------------------------------------------------------
// lcd_nibble_tx -- drives the 4-bit HD44780 bus for one transfer at a time
// and owns every timing counter, including the power-up wait after reset.
//   clk, rst          clock, async active-low reset
//   start_i           begin a transfer (accepted when idle or on done_o)
//   byte_i, rs_i      byte and register select to send
//   nibble_only_i     send only byte_i[7:4] (init nibbles)
//   post_wait_i       cycles of idle after the final E fall
//   sf_d_o, lcd_e_o, lcd_rs_o   LCD pins
//   done_o            last cycle of the post wait (also ends the power-up wait)
// Transfer shape: setup, E high, [gap, setup, E high], post wait.
// ---------------------------------------------------------------------------
module lcd_nibble_tx
   import lcd_pkg::*;
#(
   parameter int unsigned T_PWRUP = DEF_T_PWRUP,
   parameter int unsigned T_SETUP = DEF_T_SETUP,
   parameter int unsigned T_EHIGH = DEF_T_EHIGH,
   parameter int unsigned T_NIB   = DEF_T_NIB
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [7:0]  byte_i,
   input  logic        rs_i,
   input  logic        nibble_only_i,
   input  logic [31:0] post_wait_i,
   output logic [3:0]  sf_d_o,
   output logic        lcd_e_o,
   output logic        lcd_rs_o,
   output logic        done_o
);

   tx_phase_e   phase_q, phase_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] wait_q, wait_d;
   logic [3:0]  d_q, d_d;
   logic [3:0]  lo_q, lo_d;
   logic        rs_q, rs_d;
   logic        e_q, e_d;
   logic        nib_q, nib_d;
   logic        second_q, second_d;
   logic        cnt_zero;

   assign cnt_zero = (cnt_q == 32'd0);
   assign done_o   = (phase_q == TX_WAIT) && cnt_zero;
   assign sf_d_o   = d_q;
   assign lcd_e_o  = e_q;
   assign lcd_rs_o = rs_q;

   always_comb begin
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      wait_d   = wait_q;
      d_d      = d_q;
      lo_d     = lo_q;
      rs_d     = rs_q;
      e_d      = e_q;
      nib_d    = nib_q;
      second_d = second_q;

      if (phase_q != TX_IDLE && !cnt_zero)
         cnt_d = cnt_q - 32'd1;

      unique case (phase_q)
         TX_SETUP: if (cnt_zero) begin
            phase_d = TX_EHI;
            cnt_d   = T_EHIGH - 1;
            e_d     = 1'b1;
         end
         TX_EHI: if (cnt_zero) begin
            e_d = 1'b0;
            if (nib_q || second_q) begin
               phase_d = TX_WAIT;
               cnt_d   = wait_q - 32'd1;
            end else begin
               // high nibble stays on the bus through the gap
               phase_d = TX_GAP;
               cnt_d   = T_NIB - 1;
            end
         end
         TX_GAP: if (cnt_zero) begin
            phase_d  = TX_SETUP;
            cnt_d    = T_SETUP - 1;
            d_d      = lo_q;
            second_d = 1'b1;
         end
         TX_WAIT: if (cnt_zero) phase_d = TX_IDLE;
         default: ;
      endcase

      // Back-to-back transfers: the next one starts on the cycle after the
      // previous wait expires, so the sequencer never sees a dead cycle.
      if (start_i && (phase_q == TX_IDLE || done_o)) begin
         phase_d  = TX_SETUP;
         cnt_d    = T_SETUP - 1;
         d_d      = byte_i[7:4];
         lo_d     = byte_i[3:0];
         rs_d     = rs_i;
         nib_d    = nibble_only_i;
         second_d = 1'b0;
         wait_d   = post_wait_i;
      end
   end

   // Reset lands in the wait phase so the power-up delay reuses the counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q  <= TX_WAIT;
         cnt_q    <= T_PWRUP - 1;
         wait_q   <= 32'd0;
         d_q      <= 4'h0;
         lo_q     <= 4'h0;
         rs_q     <= 1'b0;
         e_q      <= 1'b0;
         nib_q    <= 1'b0;
         second_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         wait_q   <= wait_d;
         d_q      <= d_d;
         lo_q     <= lo_d;
         rs_q     <= rs_d;
         e_q      <= e_d;
         nib_q    <= nib_d;
         second_q <= second_d;
      end
   end

endmodule

// File: rtl/lcd_char_driver.sv
// ---------------------------------------------------------------------------
// lcd_char_driver -- 2x16 character frame buffer plus HD44780 sequencer.
// Runs power-on init after reset, then streams the whole frame on repaint.
//   clk, rst        clock, async active-low reset
//   dat, addr, we   buffer write port (0-15 line 1, 16-31 line 2)
//   repaint         single-cycle paint request; coalesced while busy
//   busy            high during init and paint
//   SF_D, LCD_E, LCD_RS   LCD 4-bit bus (RW tied low externally)
// ---------------------------------------------------------------------------
module lcd_char_driver
   import lcd_pkg::*;
#(
   parameter int unsigned T_PWRUP = DEF_T_PWRUP,
   parameter int unsigned T_INIT1 = DEF_T_INIT1,
   parameter int unsigned T_INIT2 = DEF_T_INIT2,
   parameter int unsigned T_SETUP = DEF_T_SETUP,
   parameter int unsigned T_EHIGH = DEF_T_EHIGH,
   parameter int unsigned T_NIB   = DEF_T_NIB,
   parameter int unsigned T_CMD   = DEF_T_CMD,
   parameter int unsigned T_CLR   = DEF_T_CLR
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] dat,
   input  logic [4:0] addr,
   input  logic       we,
   input  logic       repaint,
   output logic       busy,
   output logic [3:0] SF_D,
   output logic       LCD_E,
   output logic       LCD_RS
);

   lcd_state_e       state_q, state_d;
   logic [5:0]       idx_q, idx_d;
   logic             pending_q, pending_d;
   logic [31:0][7:0] mem_q;

   logic             tx_start;
   logic             tx_done;
   lcd_req_t         tx_req;
   logic [4:0]       rd_pos;
   logic [7:0]       rd_byte;

   // Frame buffer: writable in every state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    mem_q <= {32{8'h20}};
      else if (we) mem_q[addr] <= dat;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_PWR_WAIT;
         idx_q     <= 6'd0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
      end
   end

   // Next state. Each step issues its transfer on the cycle the previous
   // one reports done, so the tx request is decoded from state_d/idx_d.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      tx_start  = 1'b0;

      if (repaint && state_q != S_IDLE) pending_d = 1'b1;

      unique case (state_q)
         S_PWR_WAIT: if (tx_done) begin
            state_d  = S_INIT;
            idx_d    = 6'd0;
            tx_start = 1'b1;
         end
         S_INIT: if (tx_done) begin
            tx_start = 1'b1;
            if (idx_q == 6'd3) begin
               state_d = S_CFG;
               idx_d   = 6'd0;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_CFG, S_PAINT: if (tx_done) begin
            if ((state_q == S_CFG   && idx_q == 6'd3) ||
                (state_q == S_PAINT && idx_q == PAINT_LAST)) begin
               // pending_d already includes a repaint arriving this cycle
               if (pending_d) begin
                  state_d   = S_PAINT;
                  idx_d     = 6'd0;
                  tx_start  = 1'b1;
                  pending_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               idx_d    = idx_q + 6'd1;
               tx_start = 1'b1;
            end
         end
         S_IDLE: if (repaint) begin
            state_d  = S_PAINT;
            idx_d    = 6'd0;
            tx_start = 1'b1;
         end
         default: state_d = S_PWR_WAIT;
      endcase
   end

   // A write in the same cycle as the read is forwarded so it is never lost.
   assign rd_pos  = paint_pos(idx_d);
   assign rd_byte = (we && addr == rd_pos) ? dat : mem_q[rd_pos];

   // Outputs
   always_comb begin
      busy            = (state_q != S_IDLE);
      tx_req.data     = 8'h00;
      tx_req.rs       = 1'b0;
      tx_req.nib_only = 1'b0;
      tx_req.wait_cyc = T_CMD;
      unique case (state_d)
         S_INIT: begin
            tx_req.nib_only = 1'b1;
            tx_req.data     = (idx_d == 6'd3) ? 8'h20 : 8'h30;
            if (idx_d == 6'd0)      tx_req.wait_cyc = T_INIT1;
            else if (idx_d == 6'd1) tx_req.wait_cyc = T_INIT2;
         end
         S_CFG: begin
            tx_req.data = cfg_byte(idx_d[1:0]);
            if (idx_d == 6'd3) tx_req.wait_cyc = T_CLR;
         end
         S_PAINT: begin
            if (idx_d == 6'd0)           tx_req.data = LINE1;
            else if (idx_d == LINE2_IDX) tx_req.data = LINE2;
            else begin
               tx_req.data = rd_byte;
               tx_req.rs   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   lcd_nibble_tx #(
      .T_PWRUP (T_PWRUP),
      .T_SETUP (T_SETUP),
      .T_EHIGH (T_EHIGH),
      .T_NIB   (T_NIB)
   ) u_tx (
      .clk           (clk),
      .rst           (rst),
      .start_i       (tx_start),
      .byte_i        (tx_req.data),
      .rs_i          (tx_req.rs),
      .nibble_only_i (tx_req.nib_only),
      .post_wait_i   (tx_req.wait_cyc),
      .sf_d_o        (SF_D),
      .lcd_e_o       (LCD_E),
      .lcd_rs_o      (LCD_RS),
      .done_o        (tx_done)
   );

endmodule

// File: tb/tb_lcd_char_driver.sv
// ---------------------------------------------------------------------------
// tb_lcd_char_driver -- per-cycle reference timeline for the LCD pins and
// busy, plus decoded-stream literal checks for init, paint and repaint
// coalescing, same-cycle write+repaint and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_lcd_char_driver;

   localparam int P  = 100;
   localparam int I1 = 60;
   localparam int I2 = 30;
   localparam int S  = 2;
   localparam int H  = 3;
   localparam int N  = 4;
   localparam int C  = 20;
   localparam int CL = 40;

   logic       clk;
   logic       rst;
   logic [7:0] dat;
   logic [4:0] addr;
   logic       we;
   logic       repaint;
   logic       busy;
   logic [3:0] SF_D;
   logic       LCD_E;
   logic       LCD_RS;

   int total = 0;
   int bad   = 0;

   lcd_char_driver #(
      .T_PWRUP(P), .T_INIT1(I1), .T_INIT2(I2), .T_SETUP(S),
      .T_EHIGH(H), .T_NIB(N), .T_CMD(C), .T_CLR(CL)
   ) dut (
      .clk(clk), .rst(rst), .dat(dat), .addr(addr), .we(we),
      .repaint(repaint), .busy(busy), .SF_D(SF_D), .LCD_E(LCD_E),
      .LCD_RS(LCD_RS)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model: list of timed transfers ------------
   typedef struct {
      bit         nib;
      bit         rs;
      bit         from_buf;   // val holds a buffer position until started
      logic [7:0] val;
      int         wt;
   } op_t;

   op_t        q[$];
   op_t        cur;
   bit         act, have, m_busy, m_pend;
   int         t0, cyc;
   logic [7:0] mbuf [32];

   function automatic int oplen(input op_t o);
      return o.nib ? S + H + o.wt : 2*S + 2*H + N + o.wt;
   endfunction

   function automatic op_t mk(input bit nib, input bit rs, input bit fb,
                              input logic [7:0] v, input int wt);
      op_t o;
      o.nib = nib; o.rs = rs; o.from_buf = fb; o.val = v; o.wt = wt;
      return o;
   endfunction

   task automatic load_init;
      q.push_back(mk(1, 0, 0, 8'h30, I1));
      q.push_back(mk(1, 0, 0, 8'h30, I2));
      q.push_back(mk(1, 0, 0, 8'h30, C));
      q.push_back(mk(1, 0, 0, 8'h20, C));
      q.push_back(mk(0, 0, 0, 8'h28, C));
      q.push_back(mk(0, 0, 0, 8'h06, C));
      q.push_back(mk(0, 0, 0, 8'h0C, C));
      q.push_back(mk(0, 0, 0, 8'h01, CL));
   endtask

   task automatic load_paint;
      q.push_back(mk(0, 0, 0, 8'h80, C));
      for (int i = 0; i < 16; i++) q.push_back(mk(0, 1, 1, 8'(i), C));
      q.push_back(mk(0, 0, 0, 8'hC0, C));
      for (int i = 16; i < 32; i++) q.push_back(mk(0, 1, 1, 8'(i), C));
   endtask

   task automatic start_next;
      cur = q.pop_front();
      if (cur.from_buf) cur.val = mbuf[cur.val[4:0]];
      t0   = cyc;
      act  = 1;
      have = 1;
   endtask

   task automatic model_reset;
      q.delete();
      act = 0; have = 0; m_busy = 1; m_pend = 0; cyc = 0; t0 = 0;
      for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else begin
            cyc++;
            if (we) mbuf[addr] = dat;
            if (repaint && m_busy) m_pend = 1;
            if (cyc == P) begin
               load_init();
               start_next();
            end else if (act && cyc == t0 + oplen(cur)) begin
               if (q.size() != 0) start_next();
               else if (m_pend) begin
                  m_pend = 0;
                  load_paint();
                  start_next();
               end else begin
                  act = 0;
                  m_busy = 0;
               end
            end else if (!m_busy && repaint) begin
               m_busy = 1;
               load_paint();
               start_next();
            end
         end
      end
   end

   // ---------------- per-cycle compare ------------------------------------
   initial begin
      logic       e_x;
      logic [3:0] d_x;
      logic       rs_x;
      int         r;
      forever begin
         @(negedge clk);
         if (rst) begin
            e_x = 0; d_x = 4'h0; rs_x = 0;
            if (have) begin
               r    = cyc - t0;
               rs_x = cur.rs;
               if (act) begin
                  e_x = (r >= S && r < S + H) ||
                        (!cur.nib && r >= 2*S + H + N && r < 2*S + 2*H + N);
                  d_x = (cur.nib || r < S + H + N) ? cur.val[7:4] : cur.val[3:0];
               end else begin
                  d_x = cur.nib ? cur.val[7:4] : cur.val[3:0];
               end
            end
            total++;
            if (LCD_E !== e_x || SF_D !== d_x || LCD_RS !== rs_x || busy !== m_busy) begin
               bad++;
               $display("FAIL pins cyc %0d: E/D/RS/busy got %b/%h/%b/%b want %b/%h/%b/%b",
                        cyc, LCD_E, SF_D, LCD_RS, busy, e_x, d_x, rs_x, m_busy);
            end
         end
      end
   end

   // ---------------- bus decoder: {RS, nibble} at each E rise -------------
   logic [4:0] nlog[$];
   initial begin
      logic eprev;
      eprev = 0;
      forever begin
         @(negedge clk);
         if (!rst) eprev = 0;
         else begin
            if (LCD_E && !eprev) nlog.push_back({LCD_RS, SF_D});
            eprev = LCD_E;
         end
      end
   end

   // {rs, byte} of the k-th byte after nibble offset base
   function automatic int nb(input int base, input int k);
      return {nlog[base + 2*k][4], nlog[base + 2*k][3:0], nlog[base + 2*k + 1][3:0]};
   endfunction

   function automatic int cfg_exp(input int k);
      case (k)
         0: return 'h28;
         1: return 'h06;
         2: return 'h0C;
         default: return 'h01;
      endcase
   endfunction

   task automatic drive(input bit w, input int a, input int d, input bit rp);
      we = w; addr = 5'(a); dat = 8'(d); repaint = rp;
      @(negedge clk);
      we = 0; repaint = 0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 8000) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_idle"}, busy, 0);
   endtask

   task automatic check_init(input string nm);
      chk({nm, "_cnt"}, nlog.size(), 12);
      if (nlog.size() >= 12) begin
         for (int k = 0; k < 4; k++)
            chk($sformatf("%s_nib%0d", nm, k), nlog[k], (k == 3) ? 'h02 : 'h03);
         for (int k = 0; k < 4; k++)
            chk($sformatf("%s_byte%0d", nm, k), nb(4, k), cfg_exp(k));
      end
   endtask

   initial begin
      int n;
      int ex;
      rst = 0; we = 0; repaint = 0; addr = 0; dat = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 1);
      chk("rst_e", LCD_E, 0);
      chk("rst_d", SF_D, 0);
      chk("rst_rs", LCD_RS, 0);
      @(negedge clk);
      rst = 1;

      // power-on init
      wait_idle("init");
      check_init("init");

      // A at 0, Z at 31, then paint
      nlog.delete();
      drive(1, 0, 'h41, 0);
      drive(1, 31, 'h5A, 0);
      drive(0, 0, 0, 1);
      wait_idle("paint1");
      chk("paint1_cnt", nlog.size(), 68);
      if (nlog.size() >= 68)
         for (int k = 0; k < 34; k++) begin
            if (k == 0)       ex = 'h080;
            else if (k == 17) ex = 'h0C0;
            else if (k == 1)  ex = 'h141;
            else if (k == 33) ex = 'h15A;
            else              ex = 'h120;
            chk($sformatf("paint1_b%0d", k), nb(0, k), ex);
         end

      // three repaints during a paint coalesce into one more paint
      nlog.delete();
      drive(0, 0, 0, 1);
      repeat (200) @(negedge clk);
      drive(0, 0, 0, 1);
      repeat (150) @(negedge clk);
      drive(0, 0, 0, 1);
      repeat (150) @(negedge clk);
      drive(0, 0, 0, 1);
      wait_idle("coal");
      chk("coal_cnt", nlog.size(), 136);
      if (nlog.size() >= 136) begin
         chk("coal_hdr2", nb(68, 0), 'h080);
         chk("coal_z2", nb(68, 33), 'h15A);
      end

      // write and repaint in the same cycle; addr 20 is stream byte 22
      nlog.delete();
      drive(1, 20, 'h31, 1);
      wait_idle("same");
      chk("same_cnt", nlog.size(), 68);
      if (nlog.size() >= 68) begin
         chk("same_b22", nb(0, 22), 'h131);
         chk("same_b21", nb(0, 21), 'h120);
      end

      // repaint during init: one paint follows init
      #1 rst = 0;
      @(negedge clk);
      rst = 1;
      nlog.delete();
      repeat (50) @(negedge clk);
      drive(0, 0, 0, 1);
      repeat (200) @(negedge clk);
      drive(0, 0, 0, 1);
      wait_idle("initrp");
      chk("initrp_cnt", nlog.size(), 80);
      if (nlog.size() >= 80) begin
         chk("initrp_hdr", nb(12, 0), 'h080);
         chk("initrp_b1", nb(12, 1), 'h120);
      end

      // randomized writes and repaints, checked cycle by cycle
      for (int i = 0; i < 4000; i++) begin
         we      = ($urandom_range(3) == 0);
         addr    = 5'($urandom_range(31));
         dat     = 8'($urandom_range(255));
         repaint = ($urandom_range(399) == 0);
         @(negedge clk);
      end
      we = 0; repaint = 0;
      wait_idle("rand");

      // fill buffer, then reset while E is high mid-paint
      for (int i = 0; i < 32; i++) drive(1, i, 'h41 + i, 0);
      drive(0, 0, 0, 1);
      repeat (300) @(negedge clk);
      n = 0;
      while (LCD_E !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("pre_rst_e", LCD_E, 1);
      #1 rst = 0;
      #1;
      chk("async_e", LCD_E, 0);
      chk("async_busy", busy, 1);
      @(negedge clk);
      rst = 1;
      nlog.delete();
      wait_idle("reinit");
      check_init("reinit");
      nlog.delete();
      drive(0, 0, 0, 1);
      wait_idle("post");
      chk("post_cnt", nlog.size(), 68);
      if (nlog.size() >= 68)
         for (int k = 1; k < 34; k++)
            if (k != 17) chk($sformatf("post_b%0d", k), nb(0, k), 'h120);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
